// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, constants, FSM states and packing helper.
package fp32_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 24;
    localparam int unsigned FRAC_W  = MAN_W - 1;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;
    localparam int unsigned IEXP_W  = 10;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;
    localparam logic [31:0] ZERO = 32'h0000_0000;

    // Internal exponent: signed, wide enough to see past 0 and 255
    typedef logic signed [IEXP_W-1:0] iexp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] fp32_pack(input logic s,
                                              input logic [EXP_W-1:0] e,
                                              input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fp32_rne_rounder.sv
// Round-to-nearest-even on a normalized 24-bit mantissa with G/R/S bits.
module fp32_rne_rounder
    import fp32_pkg::*;
(
    input  logic [MAN_W-1:0] man_i,
    input  logic [2:0]       grs_i,
    input  iexp_t            exp_i,
    output logic [MAN_W-1:0] man_c,
    output logic [EXP_W-1:0] exp_c,
    output logic             ovf_c
);

    logic          inc_c;
    logic [MAN_W:0] sum_c;
    iexp_t         exp_r_c;

    // Increment on G when above half or on a tie with odd lsb; renormalize on carry
    always_comb begin
        inc_c = grs_i[2] & (grs_i[1] | grs_i[0] | man_i[0]);
        sum_c = {1'b0, man_i} + (MAN_W+1)'(inc_c);
        if (sum_c[MAN_W]) begin
            man_c   = {1'b1, FRAC_W'(0)};
            exp_r_c = exp_i + iexp_t'(1);
        end else begin
            man_c   = sum_c[MAN_W-1:0];
            exp_r_c = exp_i;
        end
        ovf_c = (exp_r_c >= iexp_t'(EXP_MAX));
        exp_c = exp_r_c[EXP_W-1:0];
    end

endmodule

// File: rtl/fp32_normalize_round.sv
// Post-add normalize (right 1 on carry, left 1/cycle on cancellation), RNE round, pack.
module fp32_normalize_round
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MAN_W:0]    in_man,
    input  logic [2:0]        in_grs,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_overflow,
    output logic              out_underflow
);

    state_e          state_q, state_d;
    logic            sign_q, sign_d;
    iexp_t           exp_q, exp_d;
    logic [MAN_W:0]  man_q, man_d;
    logic [2:0]      grs_q, grs_d;
    logic            zero_q, zero_d;
    logic            unf_q, unf_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     result_q, result_d;
    logic            ovf_out_q, ovf_out_d;
    logic            unf_out_q, unf_out_d;

    logic [MAN_W-1:0] man_rnd_c;
    logic [EXP_W-1:0] exp_rnd_c;
    logic             ovf_rnd_c;

    fp32_rne_rounder u_rounder (
        .man_i (man_q[MAN_W-1:0]),
        .grs_i (grs_q),
        .exp_i (exp_q),
        .man_c (man_rnd_c),
        .exp_c (exp_rnd_c),
        .ovf_c (ovf_rnd_c)
    );

    // Next-state, datapath and output-register logic
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        man_d       = man_q;
        grs_d       = grs_q;
        zero_d      = zero_q;
        unf_d       = unf_q;
        result_d    = result_q;
        ovf_out_d   = ovf_out_q;
        unf_out_d   = unf_out_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d  = in_sign;
                    exp_d   = iexp_t'({2'b00, in_exp});
                    man_d   = in_man;
                    grs_d   = in_grs;
                    zero_d  = 1'b0;
                    unf_d   = 1'b0;
                    // Exact zero is not an underflow; a zero exponent is flushed
                    if (in_man == '0 && in_grs == 3'b000) begin
                        zero_d = 1'b1;
                    end else if (in_exp == '0) begin
                        zero_d = 1'b1;
                        unf_d  = 1'b1;
                    end
                    state_d = NORM;
                end
            end
            NORM: begin
                if (zero_q) begin
                    state_d = ROUND;
                end else if (man_q[MAN_W]) begin
                    // Carry-out: the following cycle sees bit 23 set and moves on
                    man_d = {1'b0, man_q[MAN_W:1]};
                    grs_d = {man_q[0], grs_q[2], grs_q[1] | grs_q[0]};
                    exp_d = exp_q + iexp_t'(1);
                end else if (man_q[MAN_W-1]) begin
                    state_d = ROUND;
                end else if (exp_q == iexp_t'(1)) begin
                    zero_d  = 1'b1;
                    unf_d   = 1'b1;
                    state_d = ROUND;
                end else begin
                    man_d = {1'b0, man_q[MAN_W-2:0], grs_q[2]};
                    grs_d = {grs_q[1], grs_q[0], grs_q[0]};
                    exp_d = exp_q - iexp_t'(1);
                end
            end
            ROUND: begin
                // A clear hidden bit means nothing normalized survived
                if (zero_q || !man_rnd_c[MAN_W-1]) begin
                    result_d  = ZERO;
                    ovf_out_d = 1'b0;
                end else if (ovf_rnd_c) begin
                    result_d  = {sign_q, INF[30:0]};
                    ovf_out_d = 1'b1;
                end else begin
                    result_d  = fp32_pack(sign_q, exp_rnd_c, man_rnd_c[FRAC_W-1:0]);
                    ovf_out_d = 1'b0;
                end
                unf_out_d = unf_q;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            man_q       <= '0;
            grs_q       <= '0;
            zero_q      <= 1'b0;
            unf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_out_q   <= 1'b0;
            unf_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            man_q       <= man_d;
            grs_q       <= grs_d;
            zero_q      <= zero_d;
            unf_q       <= unf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_out_q   <= ovf_out_d;
            unf_out_q   <= unf_out_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_result    = result_q;
    assign out_overflow  = ovf_out_q;
    assign out_underflow = unf_out_q;

endmodule

// File: tb/tb_fp32_normalize_round.sv
// Directed-vector bench for fp32_normalize_round.
module tb_fp32_normalize_round;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_man;
    logic [2:0]  in_grs;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    int checks;
    int failures;

    fp32_normalize_round dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_man        (in_man),
        .in_grs        (in_grs),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Accept one input, measure latency to out_valid; leaves the result held in DONE
    task automatic send(input string tag, input logic s, input logic [7:0] e,
                        input logic [24:0] m, input logic [2:0] g, output int lat);
        @(negedge clk);
        check({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
        in_sign  = s;
        in_exp   = e;
        in_man   = m;
        in_grs   = g;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                           input logic [24:0] m, input logic [2:0] g,
                           input logic [31:0] exp_res, input logic exp_ovf,
                           input logic exp_unf, input int exp_lat);
        int lat;
        send(tag, s, e, m, g, lat);
        check({tag, "/latency"},   32'(lat), 32'(exp_lat));
        check({tag, "/result"},    out_result, exp_res);
        check({tag, "/overflow"},  32'(out_overflow), 32'(exp_ovf));
        check({tag, "/underflow"}, 32'(out_underflow), 32'(exp_unf));
        check({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
        release_result(tag);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] held;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_man    = '0;
        in_grs    = '0;
        out_ready = 1'b0;

        #12;
        check("rst/in_ready",  32'(in_ready), 32'd1);
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/result",    out_result, 32'h0);
        check("rst/overflow",  32'(out_overflow), 32'd0);
        check("rst/underflow", 32'(out_underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //       tag          s     exp      man          grs     result        ovf   unf   lat
        run_vec("one_plus_one", 1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 1'b0, 1'b0, 3);
        run_vec("cancel23",     1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 1'b0, 1'b0, 25);
        run_vec("rnd_carry",    1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h40000000, 1'b0, 1'b0, 2);
        run_vec("rnd_none",     1'b0, 8'd127, 25'h0FFFFFF, 3'b011, 32'h3FFFFFFF, 1'b0, 1'b0, 2);
        run_vec("rnd_up",       1'b0, 8'd127, 25'h0800001, 3'b110, 32'h3F800002, 1'b0, 1'b0, 2);
        run_vec("tie_even",     1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 1'b0, 1'b0, 2);
        run_vec("neg_shl1",     1'b1, 8'd130, 25'h0400000, 3'b100, 32'hC0800001, 1'b0, 1'b0, 3);
        run_vec("shr_round",    1'b0, 8'd127, 25'h1000003, 3'b000, 32'h40000002, 1'b0, 1'b0, 3);
        run_vec("overflow",     1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 1'b1, 1'b0, 3);
        run_vec("underflow",    1'b0, 8'd5,   25'h0000001, 3'b000, 32'h00000000, 1'b0, 1'b1, 6);
        run_vec("neg_zero",     1'b1, 8'd100, 25'h0000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 2);

        // Backpressure: result held five cycles while a second input is offered
        send("bp", 1'b0, 8'd127, 25'h1000000, 3'b000, lat);
        check("bp/latency", 32'(lat), 32'd3);
        held = out_result;
        check("bp/result", held, 32'h40000000);
        @(negedge clk);
        in_man   = 25'h0800000;
        in_exp   = 8'd100;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp/hold_result", out_result, 32'h40000000);
            check("bp/hold_valid",  32'(out_valid), 32'd1);
            check("bp/hold_ready",  32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_result("bp");
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("bp/no_second", 32'(seen), 32'd0);

        // Reset during NORM aborts silently
        @(negedge clk);
        in_sign  = 1'b0;
        in_exp   = 8'd127;
        in_man   = 25'h0000001;
        in_grs   = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst/in_ready",  32'(in_ready), 32'd1);
        check("midrst/out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("midrst/no_result", 32'(seen), 32'd0);

        // Block still works after the abort
        run_vec("post_rst", 1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 1'b0, 1'b0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound the whole run in case the DUT stalls somewhere unexpected
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
